// File: rtl/goertzel_bank.sv
// goertzel_bank: NF parallel Goertzel filters over one NS-sample block; complex (MODE 0) or power (MODE 1) result per bin.
// Latency: last sample accepted at edge T -> FINAL during cycle T+1, first result valid from cycle T+2.
// Backpressure: s_ready only while accumulating; each result is held stable until m_ready, bins in order 0..NF-1.
module goertzel_bank #(
    parameter int NF   = 11,
    parameter int NS   = 1000,
    parameter int DW   = 8,
    parameter int CW   = 18,
    parameter int AW   = 40,
    parameter int MODE = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [NF*CW-1:0]            alpha_i,
    input  logic [NF*CW-1:0]            cos_i,
    input  logic [NF*CW-1:0]            sin_i,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [DW-1:0]        s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(NF)-1:0]       m_idx,
    output logic                        m_last,
    output logic signed [AW-1:0]        m_re,
    output logic signed [AW-1:0]        m_im,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf
);

    localparam int IW   = $clog2(NF);
    localparam int CNTW = $clog2(NS);
    localparam int FB   = CW - 3;
    // Working width holds the widest intermediate (alpha*s1*s2) with headroom for the sums.
    localparam int PW   = CW + 2*AW + 2;
    localparam logic signed [PW-1:0] HI = PW'({(AW-1){1'b1}});
    localparam logic signed [PW-1:0] LO = ~HI;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FINAL = 2'd2, OUTPUT = 2'd3} state_t;

    function automatic logic signed [PW-1:0] ext_d(input logic signed [DW-1:0] v);
        return {{(PW-DW){v[DW-1]}}, v};
    endfunction
    function automatic logic signed [PW-1:0] ext_c(input logic signed [CW-1:0] v);
        return {{(PW-CW){v[CW-1]}}, v};
    endfunction
    function automatic logic signed [PW-1:0] ext_a(input logic signed [AW-1:0] v);
        return {{(PW-AW){v[AW-1]}}, v};
    endfunction
    function automatic logic clip(input logic signed [PW-1:0] v);
        return (v > HI) || (v < LO);
    endfunction
    function automatic logic signed [AW-1:0] sat_aw(input logic signed [PW-1:0] v);
        if (v > HI) return HI[AW-1:0];
        if (v < LO) return LO[AW-1:0];
        return v[AW-1:0];
    endfunction

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic signed [CW-1:0]   alpha_q [NF], alpha_d [NF];
    logic signed [CW-1:0]   cos_q   [NF], cos_d   [NF];
    logic signed [CW-1:0]   sin_q   [NF], sin_d   [NF];
    logic signed [AW-1:0]   s1_q    [NF], s1_d    [NF];
    logic signed [AW-1:0]   s2_q    [NF], s2_d    [NF];
    logic signed [AW-1:0]   re_q    [NF], re_d    [NF];
    logic signed [AW-1:0]   im_q    [NF], im_d    [NF];
    logic                   ovf_q, ovf_d, done_q, done_d;
    logic                   s_ready_q, s_ready_d, m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d, busy_q, busy_d;

    logic signed [PW-1:0]   x_e;
    logic signed [PW-1:0]   a_e [NF], c_e [NF], n_e [NF], s1_e [NF], s2_e [NF];
    logic signed [PW-1:0]   s0_w [NF], re_w [NF], im_w [NF];

    // Sign-extend to the working width, then form the per-bin recurrence and the final results.
    always_comb begin
        x_e = ext_d(s_data);
        for (int k = 0; k < NF; k++) begin
            a_e[k]  = ext_c(alpha_q[k]);
            c_e[k]  = ext_c(cos_q[k]);
            n_e[k]  = ext_c(sin_q[k]);
            s1_e[k] = ext_a(s1_q[k]);
            s2_e[k] = ext_a(s2_q[k]);
            s0_w[k] = x_e + ((a_e[k] * s1_e[k]) >>> FB) - s2_e[k];
            if (MODE == 1) begin
                re_w[k] = s1_e[k] * s1_e[k] + s2_e[k] * s2_e[k]
                        - ((a_e[k] * s1_e[k] * s2_e[k]) >>> FB);
                im_w[k] = '0;
            end else begin
                re_w[k] = ((s1_e[k] * c_e[k]) >>> FB) - s2_e[k];
                im_w[k] = (s1_e[k] * n_e[k]) >>> FB;
            end
        end
    end

    // Block sequencing: open on start, accumulate NS samples, finalize once, then drain bins in order.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        alpha_d = alpha_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        re_d    = re_q;
        im_d    = im_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    for (int k = 0; k < NF; k++) begin
                        alpha_d[k] = alpha_i[k*CW +: CW];
                        cos_d[k]   = cos_i[k*CW +: CW];
                        sin_d[k]   = sin_i[k*CW +: CW];
                        s1_d[k]    = '0;
                        s2_d[k]    = '0;
                    end
                end
            end
            ACCUM: begin
                if (s_valid) begin
                    for (int k = 0; k < NF; k++) begin
                        s2_d[k] = s1_q[k];
                        s1_d[k] = sat_aw(s0_w[k]);
                        if (clip(s0_w[k])) ovf_d = 1'b1;
                    end
                    if (cnt_q == CNTW'(NS-1)) state_d = FINAL;
                    else                      cnt_d   = cnt_q + 1'b1;
                end
            end
            FINAL: begin
                for (int k = 0; k < NF; k++) begin
                    re_d[k] = sat_aw(re_w[k]);
                    im_d[k] = sat_aw(im_w[k]);
                    if (clip(re_w[k]) || clip(im_w[k])) ovf_d = 1'b1;
                end
                idx_d   = '0;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (m_ready) begin
                    if (idx_q == IW'(NF-1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == ACCUM);
        m_valid_d = (state_d == OUTPUT);
        busy_d    = (state_d != IDLE);
        m_last_d  = (state_d == OUTPUT) && (idx_d == IW'(NF-1));
    end

    // State, datapath and registered handshake/status outputs; reset discards any partial block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            for (int k = 0; k < NF; k++) begin
                alpha_q[k] <= '0;
                cos_q[k]   <= '0;
                sin_q[k]   <= '0;
                s1_q[k]    <= '0;
                s2_q[k]    <= '0;
                re_q[k]    <= '0;
                im_q[k]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            alpha_q   <= alpha_d;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            re_q      <= re_d;
            im_q      <= im_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_idx   = idx_q;
    assign m_last  = m_last_q;
    assign m_re    = re_q[idx_q];
    assign m_im    = im_q[idx_q];
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_goertzel_bank.sv
// tb_goertzel_bank: three instances (complex AW=40, power AW=40, complex AW=12) driven by shared stimulus.
// Expected results come from a plain-arithmetic model of the block recurrence and final formulas.
// Covers reset, DC bin, gaps/backpressure, ignored starts, saturation and mid-block reset.
`timescale 1ns/1ps
module tb_goertzel_bank;
    localparam int NF = 2, NS = 8, DW = 8, CW = 18, FB = 15;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic [NF*CW-1:0] alpha_i = '0, cos_i = '0, sin_i = '0;
    logic s_ready [3], m_valid [3], m_last [3], busy [3], done [3], ovf [3];
    logic [0:0] m_idx [3];
    logic signed [39:0] re0, im0, re1, im1;
    logic signed [11:0] re2, im2;

    longint al [NF], co [NF], si [NF], samp [NS];
    longint er [3][NF], ei [3][NF];
    bit     eo [3];
    bit     mo;
    int     checks = 0, errors = 0;

    always #5 clk = ~clk;

    goertzel_bank #(.NF(NF), .NS(NS), .DW(DW), .CW(CW), .AW(40), .MODE(0)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .alpha_i(alpha_i), .cos_i(cos_i), .sin_i(sin_i),
        .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data), .m_valid(m_valid[0]), .m_ready(m_ready),
        .m_idx(m_idx[0]), .m_last(m_last[0]), .m_re(re0), .m_im(im0), .busy(busy[0]), .done(done[0]), .ovf(ovf[0]));
    goertzel_bank #(.NF(NF), .NS(NS), .DW(DW), .CW(CW), .AW(40), .MODE(1)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .alpha_i(alpha_i), .cos_i(cos_i), .sin_i(sin_i),
        .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data), .m_valid(m_valid[1]), .m_ready(m_ready),
        .m_idx(m_idx[1]), .m_last(m_last[1]), .m_re(re1), .m_im(im1), .busy(busy[1]), .done(done[1]), .ovf(ovf[1]));
    goertzel_bank #(.NF(NF), .NS(NS), .DW(DW), .CW(CW), .AW(12), .MODE(0)) u2 (
        .clk(clk), .rstn(rstn), .start(start), .alpha_i(alpha_i), .cos_i(cos_i), .sin_i(sin_i),
        .s_valid(s_valid), .s_ready(s_ready[2]), .s_data(s_data), .m_valid(m_valid[2]), .m_ready(m_ready),
        .m_idx(m_idx[2]), .m_last(m_last[2]), .m_re(re2), .m_im(im2), .busy(busy[2]), .done(done[2]), .ovf(ovf[2]));

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] dre(input int d);
        case (d)
            0:       return re0;
            1:       return re1;
            default: return re2;
        endcase
    endfunction
    function automatic logic signed [63:0] dim(input int d);
        case (d)
            0:       return im0;
            1:       return im1;
            default: return im2;
        endcase
    endfunction

    function automatic longint sat(input longint v, input int aw);
        longint hi, lo;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin mo = 1'b1; return hi; end
        if (v < lo) begin mo = 1'b1; return lo; end
        return v;
    endfunction

    // Reference: run the whole block in plain integer arithmetic for each instance flavour.
    task automatic run_model();
        longint s1 [NF], s2 [NF], s0;
        int aw;
        for (int d = 0; d < 3; d++) begin
            aw = (d == 2) ? 12 : 40;
            mo = 1'b0;
            for (int k = 0; k < NF; k++) begin s1[k] = 0; s2[k] = 0; end
            for (int n = 0; n < NS; n++)
                for (int k = 0; k < NF; k++) begin
                    s0    = samp[n] + ((al[k] * s1[k]) >>> FB) - s2[k];
                    s2[k] = s1[k];
                    s1[k] = sat(s0, aw);
                end
            for (int k = 0; k < NF; k++) begin
                if (d == 1) begin
                    er[d][k] = sat(s1[k]*s1[k] + s2[k]*s2[k] - ((al[k]*s1[k]*s2[k]) >>> FB), aw);
                    ei[d][k] = 0;
                end else begin
                    er[d][k] = sat(((s1[k] * co[k]) >>> FB) - s2[k], aw);
                    ei[d][k] = sat((s1[k] * si[k]) >>> FB, aw);
                end
            end
            eo[d] = mo;
        end
    endtask

    task automatic rand_bin(input int k);
        al[k] = longint'($urandom_range(0, 131072)) - 65536;
        co[k] = longint'($urandom_range(0, 65536)) - 32768;
        si[k] = longint'($urandom_range(0, 65536)) - 32768;
    endtask

    task automatic set_dc(input longint v);
        al[0] = 65536; co[0] = 32768; si[0] = 0;
        for (int k = 1; k < NF; k++) rand_bin(k);
        for (int n = 0; n < NS; n++) samp[n] = v;
        run_model();
    endtask

    task automatic set_rand();
        for (int k = 0; k < NF; k++) rand_bin(k);
        for (int n = 0; n < NS; n++)
            samp[n] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 127 : -128)
                                                  : longint'($urandom_range(0, 255)) - 128;
        run_model();
    endtask

    task automatic drive_coef(input bit scramble);
        for (int k = 0; k < NF; k++) begin
            alpha_i[k*CW +: CW] = scramble ? CW'($urandom) : al[k][CW-1:0];
            cos_i[k*CW +: CW]   = scramble ? CW'($urandom) : co[k][CW-1:0];
            sin_i[k*CW +: CW]   = scramble ? CW'($urandom) : si[k][CW-1:0];
        end
    endtask

    task automatic chk_reset(input string tg);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_srdy%0d", tg, d), s_ready[d], 0);
            chk($sformatf("%s_mvld%0d", tg, d), m_valid[d], 0);
            chk($sformatf("%s_last%0d", tg, d), m_last[d], 0);
            chk($sformatf("%s_busy%0d", tg, d), busy[d], 0);
            chk($sformatf("%s_done%0d", tg, d), done[d], 0);
            chk($sformatf("%s_ovf%0d", tg, d), ovf[d], 0);
            chk($sformatf("%s_idx%0d", tg, d), m_idx[d], 0);
            chk($sformatf("%s_re%0d", tg, d), dre(d), 0);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        drive_coef(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_coef(1'b1);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("start_busy%0d", d), busy[d], 1);
            chk($sformatf("start_srdy%0d", d), s_ready[d], 1);
            chk($sformatf("start_ovf%0d", d), ovf[d], 0);
        end
    endtask

    task automatic send_block(input bit gaps, input bit poke, input int count);
        int n = 0, guard = 0;
        while (n < count && guard < 200) begin
            @(negedge clk);
            guard++;
            start = poke && (n == 3);
            if (gaps && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = samp[n][DW-1:0];
                if (s_ready[0]) n++;
            end
        end
        chk("send_count", n, count);
    endtask

    task automatic expect_final();
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("final_mvld%0d", d), m_valid[d], 0);
            chk($sformatf("final_busy%0d", d), busy[d], 1);
            chk($sformatf("final_srdy%0d", d), s_ready[d], 0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("lat_mvld%0d", d), m_valid[d], 1);
    endtask

    task automatic check_bin(input int k);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("b%0d_mvld%0d", k, d), m_valid[d], 1);
            chk($sformatf("b%0d_idx%0d", k, d), m_idx[d], k);
            chk($sformatf("b%0d_last%0d", k, d), m_last[d], (k == NF - 1) ? 1 : 0);
            chk($sformatf("b%0d_re%0d", k, d), dre(d), er[d][k]);
            chk($sformatf("b%0d_im%0d", k, d), dim(d), ei[d][k]);
        end
    endtask

    task automatic recv_block(input int smin, input int smax, input bit poke);
        int st;
        for (int k = 0; k < NF; k++) begin
            st = $urandom_range(smin, smax);
            m_ready = 1'b0;
            for (int c = 0; c < st; c++) begin
                start = poke && (k == 0) && (c == 0);
                check_bin(k);
                @(negedge clk);
            end
            start = 1'b0;
            check_bin(k);
            m_ready = 1'b1;
            @(negedge clk);
        end
        m_ready = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("end_done%0d", d), done[d], 1);
            chk($sformatf("end_busy%0d", d), busy[d], 0);
            chk($sformatf("end_mvld%0d", d), m_valid[d], 0);
            chk($sformatf("end_ovf%0d", d), ovf[d], eo[d]);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("done_pulse%0d", d), done[d], 0);
    endtask

    task automatic dc_checks();
        chk("dc_re", re0, 80);
        chk("dc_im", im0, 0);
        chk("dc_pow", re1, 6400);
        chk("dc_pow_im", im1, 0);
    endtask

    task automatic idle_valid(input string tg);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'sd5;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s_srdy%0d", tg, d), s_ready[d], 0);
                chk($sformatf("%s_busy%0d", tg, d), busy[d], 0);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_coef(1'b1);
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rstn = 1'b1;
        idle_valid("idle");

        // DC bin, no gaps, 5-cycle stalls
        set_dc(10);
        do_start();
        send_block(1'b0, 1'b0, NS);
        expect_final();
        dc_checks();
        recv_block(5, 5, 1'b0);

        // DC bin with gaps, stalls and stray start pulses in ACCUM and OUTPUT
        set_dc(10);
        do_start();
        send_block(1'b1, 1'b1, NS);
        expect_final();
        dc_checks();
        recv_block(5, 5, 1'b1);

        // Full-scale DC saturates the narrow instance only
        set_dc(127);
        do_start();
        send_block(1'b0, 1'b0, NS);
        expect_final();
        chk("ovf_narrow", ovf[2], 1);
        chk("ovf_wide", ovf[0], 0);
        recv_block(0, 2, 1'b0);
        chk("ovf_idle", ovf[2], 1);

        // Randomized blocks
        for (int r = 0; r < 8; r++) begin
            set_rand();
            do_start();
            send_block(1'b1, 1'b0, NS);
            expect_final();
            recv_block(0, 3, 1'b0);
        end

        // Reset after the 4th sample, then a clean block
        set_dc(10);
        do_start();
        send_block(1'b0, 1'b0, 4);
        @(negedge clk);
        s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(negedge clk);
        rstn = 1'b1;
        idle_valid("post_rst");
        set_dc(10);
        do_start();
        send_block(1'b0, 1'b0, NS);
        expect_final();
        dc_checks();
        recv_block(0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/goertzel_bank.md
GOERTZEL_BANK -- requirements
Module: goertzel_bank

Interface
REQ-001 Parameters SHALL be: NF default 11, number of frequency bins; NS default 1000, samples per block; DW default 8, signed sample width; CW default 18, signed coefficient width in Q3.(CW-3); AW default 40, signed state/result width; MODE default 0 (0 = complex re/im output, 1 = power output).
REQ-002 The design SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse that latches the coefficients and opens a block.
REQ-006 alpha_i / cos_i / sin_i  in  NF x CW  per-bin 2cos(w), cos(w) and sin(w), signed Q3.(CW-3).
REQ-007 s_valid / s_ready  in / out  1 / 1  sample handshake.
REQ-008 s_data  in  DW  signed sample.
REQ-009 m_valid / m_ready  out / in  1 / 1  result handshake.
REQ-010 m_idx  out  $clog2(NF)  bin index; m_last  out  1  high on bin NF-1.
REQ-011 m_re / m_im  out  AW / AW  result; in MODE 1, m_re carries the power and m_im is 0.
REQ-012 busy  out  1  not IDLE; done  out  1  one-cycle pulse after the last result handshake; ovf  out  1  sticky saturation flag.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM, FINAL and OUTPUT; all other state encodings SHALL go to IDLE.
REQ-014 IDLE->ACCUM on start: latch alpha/cos/sin, clear s1, s2 and the sample counter for all bins, and clear ovf.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 s_ready=1 only in ACCUM.
REQ-017 On each s_valid&&s_ready, every bin k SHALL update in the same cycle: s0 = sext(s_data) + ((alpha_k*s1_k)>>>(CW-3)) - s2_k; then s2_k<=s1_k and s1_k<=sat(s0).
REQ-018 The products SHALL be full precision, with an arithmetic right shift (floor).
REQ-019 sat() SHALL clamp to the AW-bit signed range and set ovf when it clamps.
REQ-020 A cycle with s_valid=0 in ACCUM SHALL leave the state, the counter and ovf unchanged.
REQ-021 The counter SHALL count from 0 to NS-1; the handshake at count NS-1 SHALL move the FSM to FINAL at the next edge.
REQ-022 FINAL SHALL last exactly 1 cycle and register, per bin, into the result buffer:
- MODE 0: re = sat((s1*cos>>>(CW-3)) - s2), im = sat(s1*sin>>>(CW-3)).
- MODE 1: p = sat(s1*s1 + s2*s2 - (alpha*s1*s2>>>(CW-3))).
- The bin then goes to OUTPUT.
REQ-023 In OUTPUT, m_valid=1 and bins are presented in order 0..NF-1; m_idx advances on each m_valid&&m_ready.
REQ-024 m_idx/m_re/m_im/m_last SHALL hold stable while m_valid&&!m_ready.
REQ-025 The handshake on bin NF-1 SHALL go to IDLE and pulse done for 1 cycle at the next edge.
REQ-026 Latency: the last sample handshake at edge T SHALL give FINAL in cycle T+1 and m_valid=1 from cycle T+2.
REQ-027 ovf SHALL remain set until the next accepted start or reset, and stays readable in IDLE.
REQ-028 Coefficient inputs SHALL be don't-care except in the start cycle.

Reset
REQ-029 While rstn=0, asynchronously: state=IDLE, s1=s2=0, counter=0, buffer=0, m_idx=0; s_ready, m_valid, m_last, busy, done and ovf all 0.
REQ-030 Reset asserted mid-block SHALL discard all partial sums and results; after release the block SHALL accept only a new start.

Verification (NF=2, NS=8, DW=8, CW=18, AW=40)
REQ-031 DC, MODE 0: bin0 alpha=65536, cos=32768, sin=0; start; s_data=10 for 8 samples -> s1=360, s2=280; m_re=80, m_im=0 at T+2, m_idx=0.
REQ-032 Same stimulus in MODE 1 -> bin0 m_re=6400, m_im=0; m_last=1 only on bin 1; done pulses 1 cycle after the bin-1 handshake.
REQ-033 Gaps and backpressure: s_valid toggled 1/0 and m_ready held 0 for 5 cycles -> results identical to REQ-031, outputs stable while stalled, no sample lost.
REQ-034 Protocol: start pulsed during ACCUM and during OUTPUT -> ignored, counter unaffected; s_valid in IDLE -> s_ready=0, no state change.
REQ-035 Overflow: AW=12, DC bin, s_data=127 x8 -> ovf=1, results clamped to 2047/-2048; the next start clears ovf.
REQ-036 Reset after the 4th sample -> all outputs at reset values; a new start with 8 samples of 10 -> results match REQ-031.
